// File: rtl/fft_input_loader_pkg.sv
// Shared constants and state encoding for the radix-4 FFT frame loader.
package fft_input_loader_pkg;

    localparam int NUM_BANKS = 4;

    // Frame length N = 4 * 2^a_bit.
    function automatic int frame_len(input int a_bit);
        return NUM_BANKS << a_bit;
    endfunction

    // Samples per bank, N/4.
    function automatic int bank_len(input int a_bit);
        return 1 << a_bit;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_BUSY  = 2'd3
    } state_t;

endpackage

// File: rtl/fft_input_loader.sv
// Scatters one N-point ADC frame across the FFT core's four RAM banks in
// first-stage butterfly order, pulses start, and counts samples dropped while busy.
module fft_input_loader
    import fft_input_loader_pkg::*;
#(
    parameter int A_BIT = 8,
    parameter int DW    = 16,
    parameter int CW    = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iEN,
    input  logic             iVALID,
    input  logic [DW-1:0]    iDATA,
    input  logic             iRDY,
    input  logic             iCLR_DROP,
    output logic [DW-1:0]    oDATA,
    output logic [A_BIT-1:0] oADDR_WR_0,
    output logic [A_BIT-1:0] oADDR_WR_1,
    output logic [A_BIT-1:0] oADDR_WR_2,
    output logic [A_BIT-1:0] oADDR_WR_3,
    output logic             oWE_0,
    output logic             oWE_1,
    output logic             oWE_2,
    output logic             oWE_3,
    output logic             oSTART,
    output logic             oBUSY,
    output logic             oOVF,
    output logic [CW-1:0]    oDROP_CNT,
    output logic [1:0]       oSTATE
);

    localparam logic [A_BIT+1:0] LAST_N   = (A_BIT+2)'(frame_len(A_BIT) - 1);
    localparam logic [CW-1:0]    DROP_MAX = {CW{1'b1}};

    state_t                 state;
    logic [A_BIT+1:0]       n;
    logic [NUM_BANKS-1:0]   bank_sel;
    logic                   drop;

    // Upper two bits of the sample index pick the bank, the rest is the address.
    always_comb begin
        bank_sel = {{(NUM_BANKS-1){1'b0}}, 1'b1} << n[A_BIT+1:A_BIT];
    end

    assign drop   = iVALID && ((state == S_START) || (state == S_BUSY));
    assign oSTATE = state;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state      <= S_IDLE;
            n          <= '0;
            oDATA      <= '0;
            oADDR_WR_0 <= '0;
            oADDR_WR_1 <= '0;
            oADDR_WR_2 <= '0;
            oADDR_WR_3 <= '0;
            oWE_0      <= 1'b0;
            oWE_1      <= 1'b0;
            oWE_2      <= 1'b0;
            oWE_3      <= 1'b0;
            oSTART     <= 1'b0;
            oBUSY      <= 1'b0;
        end else begin
            oWE_0  <= 1'b0;
            oWE_1  <= 1'b0;
            oWE_2  <= 1'b0;
            oWE_3  <= 1'b0;
            oSTART <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (iEN) begin
                        state <= S_LOAD;
                        n     <= '0;
                    end
                end
                S_LOAD: begin
                    // Disarming abandons the partial frame; that cycle's sample is not written.
                    if (!iEN) begin
                        state <= S_IDLE;
                        n     <= '0;
                    end else if (iVALID) begin
                        oDATA      <= iDATA;
                        oADDR_WR_0 <= n[A_BIT-1:0];
                        oADDR_WR_1 <= n[A_BIT-1:0];
                        oADDR_WR_2 <= n[A_BIT-1:0];
                        oADDR_WR_3 <= n[A_BIT-1:0];
                        oWE_0      <= bank_sel[0];
                        oWE_1      <= bank_sel[1];
                        oWE_2      <= bank_sel[2];
                        oWE_3      <= bank_sel[3];
                        if (n == LAST_N) begin
                            state <= S_START;
                            n     <= '0;
                        end else begin
                            n <= n + 1'b1;
                        end
                    end
                end
                S_START: begin
                    oSTART <= 1'b1;
                    oBUSY  <= 1'b1;
                    state  <= S_BUSY;
                end
                S_BUSY: begin
                    if (iRDY) begin
                        oBUSY <= 1'b0;
                        n     <= '0;
                        state <= iEN ? S_LOAD : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oOVF      <= 1'b0;
            oDROP_CNT <= '0;
        end else if (drop) begin
            oOVF <= 1'b1;
            if (iCLR_DROP) begin
                oDROP_CNT <= {{(CW-1){1'b0}}, 1'b1};
            end else if (oDROP_CNT != DROP_MAX) begin
                oDROP_CNT <= oDROP_CNT + 1'b1;
            end
        end else if (iCLR_DROP) begin
            oOVF      <= 1'b0;
            oDROP_CNT <= '0;
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Bench for fft_input_loader: scoreboarded bank writes, start latency, drop counting.
module tb_fft_input_loader;
    import fft_input_loader_pkg::*;

    localparam int A_BIT  = 8;
    localparam int DW     = 16;
    localparam int CW     = 16;
    localparam int SAT_CW = 4;
    localparam int N      = frame_len(A_BIT);
    localparam int Q      = bank_len(A_BIT);
    localparam int EW     = 2 + A_BIT + DW;

    logic iCLK = 1'b0;
    logic iRESET, iEN, iVALID, iRDY, iCLR_DROP;
    logic [DW-1:0] iDATA;

    logic [DW-1:0]    oDATA;
    logic [A_BIT-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
    logic             oWE_0, oWE_1, oWE_2, oWE_3;
    logic             oSTART, oBUSY, oOVF;
    logic [CW-1:0]    oDROP_CNT;
    logic [1:0]       oSTATE;

    logic [DW-1:0]     s_data;
    logic [A_BIT-1:0]  s_addr_0, s_addr_1, s_addr_2, s_addr_3;
    logic              s_we_0, s_we_1, s_we_2, s_we_3;
    logic              s_start, s_busy, s_ovf;
    logic [SAT_CW-1:0] s_drop_cnt;
    logic [1:0]        s_state;

    fft_input_loader #(.A_BIT(A_BIT), .DW(DW), .CW(CW)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iEN(iEN), .iVALID(iVALID), .iDATA(iDATA),
        .iRDY(iRDY), .iCLR_DROP(iCLR_DROP), .oDATA(oDATA),
        .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1),
        .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
        .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
        .oSTART(oSTART), .oBUSY(oBUSY), .oOVF(oOVF), .oDROP_CNT(oDROP_CNT),
        .oSTATE(oSTATE)
    );

    fft_input_loader #(.A_BIT(A_BIT), .DW(DW), .CW(SAT_CW)) dut_sat (
        .iCLK(iCLK), .iRESET(iRESET), .iEN(iEN), .iVALID(iVALID), .iDATA(iDATA),
        .iRDY(iRDY), .iCLR_DROP(iCLR_DROP), .oDATA(s_data),
        .oADDR_WR_0(s_addr_0), .oADDR_WR_1(s_addr_1),
        .oADDR_WR_2(s_addr_2), .oADDR_WR_3(s_addr_3),
        .oWE_0(s_we_0), .oWE_1(s_we_1), .oWE_2(s_we_2), .oWE_3(s_we_3),
        .oSTART(s_start), .oBUSY(s_busy), .oOVF(s_ovf), .oDROP_CNT(s_drop_cnt),
        .oSTATE(s_state)
    );

    // Clock/reset
    always #5 iCLK = ~iCLK;

    int compared   = 0;
    int mismatched = 0;
    int start_count = 0;
    int drops_model = 0;
    bit ramp_capture = 0;
    logic [EW-1:0] exp_q[$];
    int seen_bank[N];
    int seen_addr[N];
    int seen_data[N];

    typedef struct {
        int idx;
        int bank;
        int addr;
    } map_vec_t;
    map_vec_t map_tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor and scoreboard
    always @(negedge iCLK) begin
        int nwe;
        int bank;
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        if (oSTART) start_count++;
        if (oWE_0 | oWE_1 | oWE_2 | oWE_3) begin
            nwe  = int'(oWE_0) + int'(oWE_1) + int'(oWE_2) + int'(oWE_3);
            bank = oWE_1 ? 1 : (oWE_2 ? 2 : (oWE_3 ? 3 : 0));
            chk("we_onehot", nwe, 1);
            chk("addr_copies", {oADDR_WR_1, oADDR_WR_2, oADDR_WR_3},
                {oADDR_WR_0, oADDR_WR_0, oADDR_WR_0});
            got = {bank[1:0], oADDR_WR_0, oDATA};
            if (ramp_capture && int'(oDATA) < N) begin
                seen_bank[int'(oDATA)] = bank;
                seen_addr[int'(oDATA)] = int'(oADDR_WR_0);
                seen_data[int'(oDATA)] = int'(oDATA);
            end
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got bank %0d addr %0d data %0d, required none",
                         bank, oADDR_WR_0, oDATA);
            end else begin
                e = exp_q.pop_front();
                chk("write_bank_addr_data", got, e);
            end
        end
    end

    // Driver tasks
    task automatic drive(input logic v, input logic [DW-1:0] d);
        iVALID = v;
        iDATA  = d;
        @(negedge iCLK);
        iVALID = 1'b0;
    endtask

    task automatic load_sample(input int idx, input logic [DW-1:0] d);
        int b;
        int a;
        b = idx / Q;
        a = idx % Q;
        exp_q.push_back({b[1:0], a[A_BIT-1:0], d});
        drive(1'b1, d);
    endtask

    task automatic load_range(input int first, input int last, input int gmin,
                              input int gmax, input bit ramp, input bit rdy_noise);
        for (int i = first; i <= last; i++) begin
            if (rdy_noise) iRDY = 1'($urandom_range(0, 1));
            load_sample(i, ramp ? DW'(i) : DW'($urandom));
            iRDY = 1'b0;
            if (i < last) repeat ($urandom_range(gmin, gmax)) drive(1'b0, '0);
        end
    endtask

    task automatic expect_start(input string name);
        int seen_at;
        int s0;
        seen_at = -1;
        s0 = start_count;
        for (int k = 1; k <= 8; k++) begin
            @(negedge iCLK);
            if (oSTART && seen_at < 0) seen_at = k;
        end
        chk({name, "_start_latency"}, seen_at, 1);
        chk({name, "_start_pulses"}, start_count - s0, 1);
        chk({name, "_busy"}, oBUSY, 1);
        chk({name, "_state_busy"}, oSTATE, S_BUSY);
    endtask

    task automatic rdy_pulse(input logic v, input logic [DW-1:0] d);
        iRDY = 1'b1;
        drive(v, d);
        iRDY = 1'b0;
    endtask

    task automatic chk_drops(input string name);
        int sat;
        sat = (drops_model > 15) ? 15 : drops_model;
        chk({name, "_cnt"}, oDROP_CNT, drops_model);
        chk({name, "_cnt_sat"}, s_drop_cnt, sat);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_data"}, oDATA, 0);
        chk({name, "_addr"}, {oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3}, 0);
        chk({name, "_we"}, {oWE_0, oWE_1, oWE_2, oWE_3}, 0);
        chk({name, "_start_busy_ovf"}, {oSTART, oBUSY, oOVF}, 0);
        chk({name, "_drop_cnt"}, oDROP_CNT, 0);
        chk({name, "_state"}, oSTATE, S_IDLE);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        logic [DW-1:0] d;
        map_tbl[0] = '{0,    0, 0};
        map_tbl[1] = '{255,  0, 255};
        map_tbl[2] = '{256,  1, 0};
        map_tbl[3] = '{300,  1, 44};
        map_tbl[4] = '{600,  2, 88};
        map_tbl[5] = '{768,  3, 0};
        map_tbl[6] = '{1023, 3, 255};
        for (int i = 0; i < N; i++) begin
            seen_bank[i] = -1;
            seen_addr[i] = -1;
            seen_data[i] = -1;
        end

        iRESET = 1'b0; iEN = 1'b0; iVALID = 1'b0; iDATA = '0;
        iRDY = 1'b0; iCLR_DROP = 1'b0;
        repeat (3) @(negedge iCLK);
        chk_all_zero("reset");
        iRESET = 1'b1;
        drive(1'b1, 16'h1234);
        chk("idle_no_drop", oDROP_CNT, 0);

        // Ramp at full rate; arming cycle carries a sample that must be ignored
        iEN = 1'b1;
        drive(1'b1, 16'hBEEF);
        ramp_capture = 1;
        load_range(0, N - 1, 0, 0, 1, 0);
        expect_start("ramp");
        ramp_capture = 0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("map_bank_%0d", map_tbl[i].idx), seen_bank[map_tbl[i].idx], map_tbl[i].bank);
            chk($sformatf("map_addr_%0d", map_tbl[i].idx), seen_addr[map_tbl[i].idx], map_tbl[i].addr);
            chk($sformatf("map_data_%0d", map_tbl[i].idx), seen_data[map_tbl[i].idx], map_tbl[i].idx);
        end

        // Gapped 1-in-3 input with random data
        rdy_pulse(1'b0, '0);
        chk("rdy_busy_low", oBUSY, 0);
        load_range(0, N - 1, 2, 2, 0, 0);
        expect_start("gapped");

        // Drops while busy, clear interplay
        chk_drops("pre_drop");
        chk("pre_drop_ovf", oOVF, 0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'($urandom));
            drops_model++;
        end
        chk_drops("ten_drops");
        chk("ten_drops_ovf", oOVF, 1);
        iCLR_DROP = 1'b1;
        drive(1'b1, DW'($urandom));
        iCLR_DROP = 1'b0;
        drops_model = 1;
        chk_drops("clr_with_drop");
        chk("clr_with_drop_ovf", oOVF, 1);
        iCLR_DROP = 1'b1;
        drive(1'b0, '0);
        iCLR_DROP = 1'b0;
        drops_model = 0;
        chk_drops("clr_only");
        chk("clr_only_ovf", oOVF, 0);
        rdy_pulse(1'b1, DW'($urandom));
        drops_model++;
        chk_drops("rdy_edge_drop");
        d = DW'($urandom);
        load_sample(0, d);
        chk("after_rdy_we0", {oWE_0, oWE_1, oWE_2, oWE_3}, 4'b1000);
        chk("after_rdy_addr", oADDR_WR_0, 0);
        chk("after_rdy_data", oDATA, d);

        // Disarm after 500 samples
        s0 = start_count;
        load_range(1, 499, 0, 1, 0, 0);
        iEN = 1'b0;
        drive(1'b1, DW'($urandom));
        chk("abort_state", oSTATE, S_IDLE);
        repeat (4) drive(1'b1, DW'($urandom));
        chk_drops("idle_strobes");
        chk("abort_no_start", start_count - s0, 0);
        iEN = 1'b1;
        drive(1'b1, DW'($urandom));
        d = DW'($urandom);
        load_sample(0, d);
        chk("rearm_we0", {oWE_0, oWE_1, oWE_2, oWE_3}, 4'b1000);
        chk("rearm_addr", oADDR_WR_0, 0);

        // Reset at sample 700, with iRDY noise ignored while loading
        load_range(1, 699, 0, 2, 0, 1);
        iRESET = 1'b0;
        drive(1'b0, '0);
        drops_model = 0;
        chk_all_zero("mid_reset");
        iRESET = 1'b1;
        drive(1'b0, '0);
        load_range(0, N - 1, 0, 3, 0, 0);
        expect_start("after_reset");
        chk("after_reset_no_extra", start_count - s0, 1);

        // Saturation of the narrow counter
        for (int k = 1; k <= 20; k++) begin
            drive(1'b1, DW'($urandom));
            drops_model++;
            chk_drops($sformatf("sat_%0d", k));
        end
        chk("sat_ovf", s_ovf, 1);

        // Completion with the loader disarmed returns to idle
        iEN = 1'b0;
        rdy_pulse(1'b0, '0);
        chk("disarmed_idle", oSTATE, S_IDLE);
        chk("disarmed_busy", oBUSY, 0);
        repeat (3) drive(1'b1, DW'($urandom));
        chk_drops("disarmed_no_drop");

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
